// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler
//   Latches hall-call and cabin-button requests into a per-floor pending mask,
//   picks the next target floor in SCAN (elevator) order and offers it to the
//   motion controller over a valid/ready handshake. The served call is cleared
//   when the controller reports arrival with done.
//
// Optional feature macro: LIFT_SERVED_CNT_EN
//   When defined, adds served_cnt[15:0], a saturating count of completed
//   services. When undefined the port and counter are absent.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   hall_vld, hall_floor  one-cycle hall-call strobe and its floor
//   cab_vld, cab_floor    one-cycle cabin-button strobe and its floor
//   car_floor             current car floor from the motion controller
//   tgt_valid, tgt_ready  target offer handshake
//   tgt_floor             offered target floor (stable while tgt_valid)
//   done                  one-cycle arrival pulse for the accepted target
//   pending               registered pending-call mask, bit i = floor i
//   dir_up                current sweep direction, 1 = up
//   busy                  high whenever the scheduler is not idle
//   req_err               one-cycle pulse when an out-of-range request is dropped
//   served_cnt            (LIFT_SERVED_CNT_EN only) completed service count

module lift_call_scheduler #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hall_vld,
  input  logic [FLOOR_W-1:0] hall_floor,
  input  logic               cab_vld,
  input  logic [FLOOR_W-1:0] cab_floor,
  input  logic [FLOOR_W-1:0] car_floor,
  output logic               tgt_valid,
  input  logic               tgt_ready,
  output logic [FLOOR_W-1:0] tgt_floor,
  input  logic               done,
  output logic [FLOORS-1:0]  pending,
  output logic               dir_up,
  output logic               busy,
  output logic               req_err
`ifdef LIFT_SERVED_CNT_EN
  ,
  output logic [15:0]        served_cnt
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SELECT    = 2'd1;
  localparam logic [1:0] ISSUE     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]         state;
  logic [FLOORS-1:0]  hall_mask;
  logic [FLOORS-1:0]  cab_mask;
  logic [FLOORS-1:0]  clr_mask;
  logic               bad_req;

  logic               have_here;
  logic               have_above;
  logic               have_below;
  logic [FLOOR_W-1:0] above;
  logic [FLOOR_W-1:0] below;
  logic [FLOOR_W-1:0] sel_floor;
  logic               sel_dir_up;
  logic [31:0]        car_ext;

  assign busy    = (state != IDLE);
  assign car_ext = 32'(car_floor);

  // Decoded request/clear masks. Only in-range floors can hit a bit, so an
  // empty mask on a valid strobe marks an out-of-range request.
  always_comb begin
    hall_mask = '0;
    cab_mask  = '0;
    clr_mask  = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (hall_vld && hall_floor == FLOOR_W'(i)) hall_mask[i] = 1'b1;
      if (cab_vld && cab_floor == FLOOR_W'(i))   cab_mask[i]  = 1'b1;
      if (state == WAIT_DONE && done && tgt_floor == FLOOR_W'(i)) clr_mask[i] = 1'b1;
    end
    bad_req = (hall_vld && hall_mask == '0) || (cab_vld && cab_mask == '0);
  end

  // SCAN selection: nearest call above (lowest) and below (highest) the car.
  always_comb begin
    have_here  = 1'b0;
    have_above = 1'b0;
    have_below = 1'b0;
    above      = '0;
    below      = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending[i] && i == car_ext) have_here = 1'b1;
      if (pending[i] && i > car_ext && !have_above) begin
        have_above = 1'b1;
        above      = FLOOR_W'(i);
      end
      if (pending[i] && i < car_ext) begin
        have_below = 1'b1;
        below      = FLOOR_W'(i);
      end
    end

    sel_floor  = car_floor;
    sel_dir_up = dir_up;
    if (have_here) begin
      sel_floor = car_floor;
    end else if (dir_up) begin
      if (have_above) begin
        sel_floor = above;
      end else begin
        sel_floor  = below;
        sel_dir_up = 1'b0;
      end
    end else begin
      if (have_below) begin
        sel_floor = below;
      end else begin
        sel_floor  = above;
        sel_dir_up = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      dir_up    <= 1'b1;
      tgt_valid <= 1'b0;
      tgt_floor <= '0;
      req_err   <= 1'b0;
`ifdef LIFT_SERVED_CNT_EN
      served_cnt <= '0;
`endif
    end else begin
      // Clear is applied after set so a coincident request for the served
      // floor is absorbed by the arrival.
      pending <= (pending | hall_mask | cab_mask) & ~clr_mask;
      req_err <= bad_req;

      case (state)
        IDLE: begin
          if (pending != '0) state <= SELECT;
        end
        SELECT: begin
          if (pending != '0) begin
            tgt_floor <= sel_floor;
            dir_up    <= sel_dir_up;
            tgt_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (tgt_ready) begin
            tgt_valid <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            state <= IDLE;
`ifdef LIFT_SERVED_CNT_EN
            if (served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed testbench for lift_call_scheduler. A FLOORS=8 instance carries the
// main scheduling sequence; a FLOORS=6 instance exercises the range check.
module tb_lift_call_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       hall_vld, cab_vld, tgt_ready, done;
  logic [2:0] hall_floor, cab_floor, car_floor;
  logic       tgt_valid, dir_up, busy, req_err;
  logic [2:0] tgt_floor;
  logic [7:0] pending;

  logic       hall_vld6, cab_vld6, tgt_ready6, done6;
  logic [2:0] hall_floor6, cab_floor6, car_floor6;
  logic       tgt_valid6, dir_up6, busy6, req_err6;
  logic [2:0] tgt_floor6;
  logic [5:0] pending6;

`ifdef LIFT_SERVED_CNT_EN
  logic [15:0] served_cnt, served_cnt6;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  lift_call_scheduler #(.FLOORS(8), .FLOOR_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .hall_vld(hall_vld), .hall_floor(hall_floor),
    .cab_vld(cab_vld), .cab_floor(cab_floor),
    .car_floor(car_floor),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_floor(tgt_floor),
    .done(done), .pending(pending), .dir_up(dir_up), .busy(busy),
    .req_err(req_err)
`ifdef LIFT_SERVED_CNT_EN
    , .served_cnt(served_cnt)
`endif
  );

  lift_call_scheduler #(.FLOORS(6), .FLOOR_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .hall_vld(hall_vld6), .hall_floor(hall_floor6),
    .cab_vld(cab_vld6), .cab_floor(cab_floor6),
    .car_floor(car_floor6),
    .tgt_valid(tgt_valid6), .tgt_ready(tgt_ready6), .tgt_floor(tgt_floor6),
    .done(done6), .pending(pending6), .dir_up(dir_up6), .busy(busy6),
    .req_err(req_err6)
`ifdef LIFT_SERVED_CNT_EN
    , .served_cnt(served_cnt6)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept the current offer, then report arrival at floor f.
  task automatic serve(input logic [2:0] f);
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;
    car_floor = f;
    done      = 1'b1;
    step();
    done      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    hall_vld = 0; cab_vld = 0; tgt_ready = 0; done = 0;
    hall_floor = 0; cab_floor = 0; car_floor = 0;
    hall_vld6 = 0; cab_vld6 = 0; tgt_ready6 = 0; done6 = 0;
    hall_floor6 = 0; cab_floor6 = 0; car_floor6 = 0;

    step();
    check("rst_pending",   32'(pending),   32'h0);
    check("rst_dir_up",    32'(dir_up),    32'h1);
    check("rst_tgt_valid", 32'(tgt_valid), 32'h0);
    check("rst_tgt_floor", 32'(tgt_floor), 32'h0);
    check("rst_req_err",   32'(req_err),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    rst_n = 1'b1;
    step();

    // Single call at floor 5 from floor 0.
    hall_vld = 1; hall_floor = 3'd5;
    step();
    hall_vld = 0;
    check("t1_pending", 32'(pending), 32'h20);
    check("t1_valid_early", 32'(tgt_valid), 32'h0);
    step();
    check("t1_busy_select", 32'(busy), 32'h1);
    check("t1_valid_select", 32'(tgt_valid), 32'h0);
    step();
    check("t1_valid", 32'(tgt_valid), 32'h1);
    check("t1_tgt", 32'(tgt_floor), 32'h5);
    tgt_ready = 1;
    step();
    tgt_ready = 0;
    check("t1_valid_drop", 32'(tgt_valid), 32'h0);
    car_floor = 3'd5; done = 1;
    step();
    done = 0;
    check("t1_pending_clr", 32'(pending), 32'h0);
    check("t1_busy_idle", 32'(busy), 32'h0);
`ifdef LIFT_SERVED_CNT_EN
    check("t1_served_cnt", 32'(served_cnt), 32'h1);
`endif

    // SCAN from floor 3 going up with calls {1,4,6}: 4, 6, then reverse to 1.
    car_floor = 3'd3;
    hall_vld = 1; hall_floor = 3'd1; cab_vld = 1; cab_floor = 3'd6;
    step();
    cab_vld = 0; hall_floor = 3'd4;
    step();
    hall_vld = 0;
    check("t2_pending", 32'(pending), 32'h52);
    step();
    check("t2_tgt4", 32'(tgt_floor), 32'h4);
    serve(3'd4);
    check("t2_pending_after4", 32'(pending), 32'h42);
    step(); step();
    check("t2_tgt6", 32'(tgt_floor), 32'h6);
    check("t2_dir_up6", 32'(dir_up), 32'h1);
    serve(3'd6);
    step(); step();
    check("t2_tgt1", 32'(tgt_floor), 32'h1);
    check("t2_dir_down", 32'(dir_up), 32'h0);
    serve(3'd1);
    check("t2_pending_empty", 32'(pending), 32'h0);
`ifdef LIFT_SERVED_CNT_EN
    check("t2_served_cnt", 32'(served_cnt), 32'h4);
`endif

    // Going down from 1 with only {3}: reverse to up.
    hall_vld = 1; hall_floor = 3'd3;
    step();
    hall_vld = 0;
    step(); step();
    check("t3_tgt3", 32'(tgt_floor), 32'h3);
    check("t3_dir_up", 32'(dir_up), 32'h1);
    serve(3'd3);

    // Car at 6 going up with only {2}: reverse to down.
    car_floor = 3'd6;
    hall_vld = 1; hall_floor = 3'd2;
    step();
    hall_vld = 0;
    step(); step();
    check("t3_tgt2", 32'(tgt_floor), 32'h2);
    check("t3_dir_down", 32'(dir_up), 32'h0);
    serve(3'd2);

    // Call at the car's own floor: served in place, direction kept.
    cab_vld = 1; cab_floor = 3'd2;
    step();
    cab_vld = 0;
    step(); step();
    check("t3_tgt_here", 32'(tgt_floor), 32'h2);
    check("t3_dir_kept", 32'(dir_up), 32'h0);
    serve(3'd2);

    // Dual strobes; range check on the six-floor instance.
    hall_vld = 1; hall_floor = 3'd2; cab_vld = 1; cab_floor = 3'd7;
    hall_vld6 = 1; hall_floor6 = 3'd5; cab_vld6 = 1; cab_floor6 = 3'd7;
    step();
    hall_vld = 0; cab_vld = 0; hall_vld6 = 0; cab_vld6 = 0;
    check("t4_pending_dual", 32'(pending), 32'h84);
    check("t4_req_err_ok", 32'(req_err), 32'h0);
    check("t4_pending6", 32'(pending6), 32'h20);
    check("t4_req_err6", 32'(req_err6), 32'h1);
    hall_vld6 = 1; hall_floor6 = 3'd6; cab_vld6 = 1; cab_floor6 = 3'd7;
    step();
    hall_vld6 = 0; cab_vld6 = 0;
    check("t4_req_err6_both", 32'(req_err6), 32'h1);
    check("t4_pending6_both", 32'(pending6), 32'h20);
    step();
    check("t4_req_err6_drop", 32'(req_err6), 32'h0);
    // Main instance now offers floor 2 (car is at 2).
    check("t4_tgt2", 32'(tgt_floor), 32'h2);
    serve(3'd2);
    step(); step();
    check("t4_tgt7", 32'(tgt_floor), 32'h7);
    check("t4_dir_up", 32'(dir_up), 32'h1);

    // Offer held with tgt_ready low while a new call arrives.
    cab_vld = 1; cab_floor = 3'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      cab_vld = 0;
      check("t5_valid_hold", 32'(tgt_valid), 32'h1);
      check("t5_tgt_hold", 32'(tgt_floor), 32'h7);
    end
    check("t5_pending", 32'(pending), 32'h82);
    serve(3'd7);
    step(); step();
    check("t5_tgt1", 32'(tgt_floor), 32'h1);
    serve(3'd1);

    // Request for the target coincident with done is absorbed.
    hall_vld = 1; hall_floor = 3'd4;
    step();
    hall_vld = 0;
    step(); step();
    check("t6_tgt4", 32'(tgt_floor), 32'h4);
    tgt_ready = 1;
    step();
    tgt_ready = 0;
    hall_vld = 1; hall_floor = 3'd4; cab_vld = 1; cab_floor = 3'd6;
    car_floor = 3'd4; done = 1;
    step();
    hall_vld = 0; cab_vld = 0; done = 0;
    check("t6_clear_wins", 32'(pending), 32'h40);
    check("t6_idle", 32'(busy), 32'h0);
    step(); step();
    check("t6_tgt6", 32'(tgt_floor), 32'h6);
    // done while offering is ignored.
    done = 1;
    step();
    done = 0;
    check("t6_done_ignored_pend", 32'(pending), 32'h40);
    check("t6_done_ignored_vld", 32'(tgt_valid), 32'h1);
    tgt_ready = 1;
    step();
    tgt_ready = 0;
    check("t6_wait_busy", 32'(busy), 32'h1);

    // Asynchronous reset in WAIT_DONE.
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_pending", 32'(pending), 32'h0);
    check("t7_rst_tgt_floor", 32'(tgt_floor), 32'h0);
    check("t7_rst_valid", 32'(tgt_valid), 32'h0);
    check("t7_rst_busy", 32'(busy), 32'h0);
    check("t7_rst_dir", 32'(dir_up), 32'h1);
    check("t7_rst_pending6", 32'(pending6), 32'h0);
`ifdef LIFT_SERVED_CNT_EN
    check("t7_rst_served_cnt", 32'(served_cnt), 32'h0);
`endif
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- Upstream stage of the car motion controller.
- Latches hall-call and cabin-button requests into a per-floor pending mask.
- Picks the next target floor using SCAN (elevator) ordering and hands it to the motion controller over a valid/ready handshake.
- Clears the served request when the controller reports arrival.

Parameters:
FLOORS, 8, number of served floors, numbered 0..FLOORS-1; must satisfy FLOORS <= 2**FLOOR_W
FLOOR_W, 3, width of every floor-number field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
hall_vld  in  1  one-cycle hall-call strobe
hall_floor  in  FLOOR_W  floor of hall call, sampled when hall_vld=1
cab_vld  in  1  one-cycle cabin-button strobe
cab_floor  in  FLOOR_W  floor of cabin button, sampled when cab_vld=1
car_floor  in  FLOOR_W  current car floor reported by motion controller
tgt_valid  out  1  target offer to motion controller
tgt_ready  in  1  motion controller accepts target
tgt_floor  out  FLOOR_W  offered target floor
done  in  1  one-cycle pulse: car arrived at accepted target
pending  out  FLOORS  registered pending-call mask, bit i = floor i
dir_up  out  1  current sweep direction, 1=up
busy  out  1  high whenever state != IDLE
req_err  out  1  one-cycle pulse: out-of-range request dropped

Behaviour:
- Reset values (async, all outputs registered):
  - state=IDLE, pending=0, dir_up=1, tgt_valid=0, tgt_floor=0, req_err=0.
  - busy=0, derived from state.
- Request capture:
  - On a clock edge with hall_vld, set pending[hall_floor]; with cab_vld, set pending[cab_floor].
  - Both strobes in the same cycle are both captured; same floor on both = one bit set.
  - The new bit is visible on pending the cycle after the strobe.
- Range check:
  - A floor >= FLOORS is not recorded.
  - req_err pulses high the following cycle; one pulse covers both sources if both are bad.
- State machine: IDLE, SELECT, ISSUE, WAIT_DONE.
- IDLE: if pending != 0, go to SELECT next cycle; otherwise stay.
- SELECT (exactly one cycle), choose target from pending and car_floor (c):
  - If pending[c]=1: target=c; dir_up unchanged.
  - Else if dir_up=1:
    - If any pending bit > c: target = lowest such floor.
    - Otherwise: dir_up<=0, target = highest pending floor < c.
  - Else if dir_up=0:
    - If any pending bit < c: target = highest such floor.
    - Otherwise: dir_up<=1, target = lowest pending floor > c.
  - Result is registered into tgt_floor; go to ISSUE.
  - pending=0 in SELECT cannot occur (bits are cleared only in WAIT_DONE); if it does, return to IDLE.
- ISSUE:
  - tgt_valid=1; tgt_floor held stable until accepted.
  - Handshake completes on a clock edge with tgt_valid & tgt_ready. Next cycle: tgt_valid=0, state=WAIT_DONE.
  - Minimum latency from pending visible in IDLE to tgt_valid high: 2 cycles.
  - New requests arriving in ISSUE do not change the offered target.
- WAIT_DONE:
  - On done=1: clear pending[tgt_floor]; go to IDLE.
  - A request for tgt_floor in the same cycle as done is dropped: clear wins, the call counts as served.
  - Requests to other floors are captured normally in every state.
  - done outside WAIT_DONE is ignored.
- Back-to-back service: IDLE -> SELECT restarts the cycle after done if pending is still non-zero.
- Reset mid-operation:
  - All pending calls are lost and tgt_valid drops immediately.
  - The motion controller must also be reset.

Optional Feature:
- Macro: LIFT_SERVED_CNT_EN.
- Defined:
  - Adds output port served_cnt [15:0], reset 0.
  - Increments by 1 on each accepted done in WAIT_DONE; saturates at 16'hFFFF.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, car_floor=0, hall_vld with hall_floor=5 -> pending=8'h20 next cycle; tgt_valid=1 with tgt_floor=5 two cycles later; tgt_ready=1 then done -> pending=0, busy=0.
- car_floor=3, dir_up=1, pending floors {1,6,4} -> first offered tgt_floor=4; after done at 4 with car_floor=4 -> next 6; after done at 6 -> dir_up=0, next 1.
- car_floor=6, dir_up=1, pending only {2} -> dir_up=0, tgt_floor=2.
- hall_vld floor 2 and cab_vld floor 7 in the same cycle -> pending=8'h84; cab_floor=3'd7 with FLOORS=6 -> bit not set, req_err one-cycle pulse.
- tgt_ready held low 10 cycles in ISSUE while new cab_vld floor 1 arrives -> tgt_valid and tgt_floor stable; pending[1] set; tgt_floor unchanged.
- In WAIT_DONE with tgt_floor=4: hall_vld floor 4 coincident with done -> pending[4]=0. Separately, assert rst_n=0 mid-WAIT_DONE -> all outputs at reset values asynchronously. With LIFT_SERVED_CNT_EN: three services -> served_cnt=3.
